// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit add/subtract split into STAGES carry-chained
// segments, one segment resolved per pipeline stage. A single global advance
// signal moves the whole pipeline forward or freezes it, so the last stage's
// registers double as the output registers and stay stable under backpressure.

// One pipeline stage: adds operand segment IDX with the incoming carry and
// forwards the operands, partial sum, carry and tag to the next stage.
module pipelined_addsub_seg #(
  parameter int WIDTH = 128,
  parameter int SEG   = 32,
  parameter int IDX   = 0,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_c,
  output logic [WIDTH-1:0] out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);
  localparam int LSB = IDX * SEG;
  localparam int MSB = LSB + SEG - 1;

  logic [SEG:0]       seg_add;
  logic               vld_d, vld_q;
  logic [WIDTH-1:0]   a_d, a_q;
  logic [WIDTH-1:0]   b_d, b_q;
  logic               c_d, c_q;
  logic [WIDTH-1:0]   sum_d, sum_q;
  logic [TAG_W-1:0]   tag_d, tag_q;
  logic               ovf_d, ovf_q;

  // Segment add; data only loads for a valid op so bubbles never disturb outputs.
  always_comb begin
    vld_d   = vld_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sum_d   = sum_q;
    tag_d   = tag_q;
    ovf_d   = ovf_q;
    seg_add = {1'b0, in_a[LSB +: SEG]} + {1'b0, in_b[LSB +: SEG]} + {{SEG{1'b0}}, in_c};
    if (adv) begin
      vld_d = in_vld;
      if (in_vld) begin
        a_d                = in_a;
        b_d                = in_b;
        c_d                = seg_add[SEG];
        sum_d              = in_sum;
        sum_d[LSB +: SEG]  = seg_add[SEG-1:0];
        // carry into this segment's MSB is a^b^s at that bit; xor with carry out
        ovf_d              = in_a[MSB] ^ in_b[MSB] ^ seg_add[SEG-1] ^ seg_add[SEG];
        tag_d              = in_tag;
      end
    end
  end

  // Stage registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= 1'b0;
      sum_q <= '0;
      tag_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      sum_q <= sum_d;
      tag_q <= tag_d;
      ovf_q <= ovf_d;
    end
  end

  assign out_vld = vld_q;
  assign out_a   = a_q;
  assign out_b   = b_q;
  assign out_c   = c_q;
  assign out_sum = sum_q;
  assign out_tag = tag_q;
  assign out_ovf = ovf_q;
endmodule

module pipelined_addsub #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);
  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: STAGES must be >= 1 and divide WIDTH");
  end

  // Index k is the input of stage k; index STAGES is the output stage.
  logic [STAGES:0]                vld_w;
  logic [STAGES:0]                c_w;
  logic [STAGES:0][WIDTH-1:0]     a_w;
  logic [STAGES:0][WIDTH-1:0]     b_w;
  logic [STAGES:0][WIDTH-1:0]     sum_w;
  logic [STAGES:0][TAG_W-1:0]     tag_w;
  logic [STAGES-1:0]              ovf_w;
  logic                           adv;
  logic                           unused_ok;

  // Whole pipeline moves when the output slot is empty or being drained.
  assign adv      = !vld_w[STAGES] || out_ready;
  assign in_ready = adv;

  // Subtract is a + ~b + ~borrow, so only the operand and carry need conditioning.
  assign vld_w[0] = in_valid;
  assign a_w[0]   = a;
  assign b_w[0]   = sub ? ~b : b;
  assign c_w[0]   = sub ? ~cin : cin;
  assign sum_w[0] = '0;
  assign tag_w[0] = tag_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_addsub_seg #(
      .WIDTH (WIDTH),
      .SEG   (SEG),
      .IDX   (k),
      .TAG_W (TAG_W)
    ) u_seg (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv),
      .in_vld  (vld_w[k]),
      .in_a    (a_w[k]),
      .in_b    (b_w[k]),
      .in_c    (c_w[k]),
      .in_sum  (sum_w[k]),
      .in_tag  (tag_w[k]),
      .out_vld (vld_w[k+1]),
      .out_a   (a_w[k+1]),
      .out_b   (b_w[k+1]),
      .out_c   (c_w[k+1]),
      .out_sum (sum_w[k+1]),
      .out_tag (tag_w[k+1]),
      .out_ovf (ovf_w[k])
    );
  end

  assign out_valid = vld_w[STAGES];
  assign sum       = sum_w[STAGES];
  assign cout      = c_w[STAGES];
  assign ovf       = ovf_w[STAGES-1];
  assign tag_out   = tag_w[STAGES];

  // Operands past the last stage and early-stage overflow flags have no consumer.
  assign unused_ok = ^{a_w[STAGES], b_w[STAGES], ovf_w};
endmodule
